// File: rtl/rib_wdt_pkg.sv
// ============================================================================
// Module      : rib_wdt_pkg
// Description : Register map, key defaults and FSM encoding for the rib watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rib_wdt_pkg;

  localparam logic [7:0] c_off_ctrl   = 8'h00;
  localparam logic [7:0] c_off_load   = 8'h04;
  localparam logic [7:0] c_off_value  = 8'h08;
  localparam logic [7:0] c_off_feed   = 8'h0C;
  localparam logic [7:0] c_off_status = 8'h10;
  localparam logic [7:0] c_off_lock   = 8'h14;

  localparam logic [31:0] c_feed_key_def   = 32'h5A5A_A5A5;
  localparam logic [31:0] c_unlock_key_def = 32'h1ACC_E551;
  localparam logic [31:0] c_load_rst       = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNT     = 2'd1,
    ST_EXPIRED   = 2'd2,
    ST_RESET_REQ = 2'd3
  } wdt_state_t;

  function automatic logic [7:0] reg_offset(input logic [31:0] addr);
    return addr[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rib_wdt_if.sv
// ============================================================================
// Module      : rib_wdt_if
// Description : rib slave bus bundle (write, address, data in/out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rib_wdt_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input  data_o);
  modport slave  (input  we_i, input  addr_i, input  data_i, output data_o);
endinterface

`default_nettype wire

// File: rtl/rib_wdt.sv
// ============================================================================
// Module      : rib_wdt
// Description : Watchdog timer on the rib bus: first miss raises TO/interrupt,
//               second consecutive miss issues a reset-request pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rib_wdt
  import rib_wdt_pkg::*;
#(
  parameter int unsigned RST_PULSE_LEN = 16,
  parameter logic [31:0] FEED_KEY      = c_feed_key_def,
  parameter logic [31:0] UNLOCK_KEY    = c_unlock_key_def
) (
  input  logic     clk,
  input  logic     rst,
  rib_wdt_if.slave bus,
  input  logic     halt_i,
  output logic     int_sig_o,
  output logic     rst_req_o
);

  localparam int unsigned c_pw = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [c_pw-1:0] c_pmax = c_pw'(RST_PULSE_LEN - 1);
  localparam logic [c_pw-1:0] c_pone = 1;

  logic [2:0]      r_ctrl;
  logic [31:0]     r_load;
  logic [31:0]     r_count;
  logic            r_to;
  logic            r_locked;
  wdt_state_t      r_state;
  logic [c_pw-1:0] r_pcnt;
  logic            r_rst_req;

  logic [7:0]  w_off;
  logic        w_ctrl_wr;
  logic        w_load_wr;
  logic        w_feed;
  logic        w_w1c_to;
  logic        w_lock_wr;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_off         = reg_offset(bus.addr_i);
  assign w_unused_addr = ^bus.addr_i[31:8];
  assign w_ctrl_wr     = bus.we_i && (w_off == c_off_ctrl) && !r_locked;
  assign w_load_wr     = bus.we_i && (w_off == c_off_load) && !r_locked;
  assign w_feed        = bus.we_i && (w_off == c_off_feed) && (bus.data_i == FEED_KEY);
  assign w_w1c_to      = bus.we_i && (w_off == c_off_status) && bus.data_i[0];
  assign w_lock_wr     = bus.we_i && (w_off == c_off_lock);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl    <= 3'b000;
      r_load    <= c_load_rst;
      r_count   <= c_load_rst;
      r_to      <= 1'b0;
      r_locked  <= 1'b0;
      r_state   <= ST_IDLE;
      r_pcnt    <= '0;
      r_rst_req <= 1'b0;
    end else begin
      if (w_load_wr) r_load <= bus.data_i;
      if (w_lock_wr) r_locked <= (bus.data_i != UNLOCK_KEY);
      // Clear first so that an expiry later in this block wins the race.
      if (w_w1c_to) r_to <= 1'b0;
      if (w_ctrl_wr && (r_state != ST_RESET_REQ)) r_ctrl <= bus.data_i[2:0];

      case (r_state)
        ST_IDLE: begin
          if (w_ctrl_wr && bus.data_i[0]) begin
            r_count <= r_load;
            r_state <= ST_COUNT;
          end
        end
        ST_COUNT, ST_EXPIRED: begin
          if (w_ctrl_wr && !bus.data_i[0]) begin
            r_state <= ST_IDLE;
          end else if (w_feed) begin
            r_count <= r_load;
            r_state <= ST_COUNT;
          end else if (!halt_i) begin
            if (r_count == 32'd0) begin
              r_to <= 1'b1;
              if ((r_state == ST_EXPIRED) && r_ctrl[1]) begin
                r_state   <= ST_RESET_REQ;
                r_rst_req <= 1'b1;
                r_pcnt    <= '0;
              end else begin
                r_count <= r_load;
                r_state <= ST_EXPIRED;
              end
            end else begin
              r_count <= r_count - 32'd1;
            end
          end
        end
        ST_RESET_REQ: begin
          if (r_pcnt == c_pmax) begin
            r_rst_req <= 1'b0;
            r_ctrl[0] <= 1'b0;
            r_pcnt    <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_pcnt <= r_pcnt + c_pone;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      c_off_ctrl:   w_rdata = {29'd0, r_ctrl};
      c_off_load:   w_rdata = r_load;
      c_off_value:  w_rdata = r_count;
      c_off_status: w_rdata = {30'd0, (r_state == ST_RESET_REQ), r_to};
      c_off_lock:   w_rdata = {31'd0, r_locked};
      default:      w_rdata = 32'd0;
    endcase
  end

  assign bus.data_o = w_rdata;
  assign int_sig_o  = r_to & r_ctrl[2];
  assign rst_req_o  = r_rst_req;

endmodule

`default_nettype wire
